// File: rtl/imem_boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_pkg
//  Purpose  : Shared types and constants for the instruction-memory boot
//             loader. It holds the loader state encoding, the width of the
//             length header and the width of the byte-in-word counter.
//  Revision : 1.0  initial release
// ============================================================================
package imem_boot_pkg;

    // The length header is two bytes wide.
    localparam int LEN_W  = 16;
    // Counts bytes 0..3 within a 32-bit word.
    localparam int BCNT_W = 2;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

endpackage : imem_boot_pkg
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : imem_word_packer
//  Purpose  : Assembles four received bytes into one little-endian 32-bit
//             word. It uses a 2-bit byte counter and a 32-bit shift buffer.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_clear       - drop any partial word and restart at byte 0
//             i_byte_stb    - i_byte is accepted this cycle
//             i_byte        - received byte
//             o_word_done   - this strobe carries the 4th byte of a word
//             o_word        - assembled word (valid the cycle after done)
//  Revision : 1.0  initial release
// ============================================================================
module imem_word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_stb,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    localparam logic [BCNT_W-1:0] c_LAST_BYTE = '1;

    logic [BCNT_W-1:0] r_cnt;
    logic [31:0]       r_buf;

    // Shifting new bytes in from the top places the first byte of the word
    // in bits [7:0] after four shifts.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (i_byte_stb) begin
            r_cnt <= r_cnt + BCNT_W'(1);
            r_buf <= {i_byte, r_buf[31:8]};
        end
    end

    assign o_word_done = i_byte_stb && (r_cnt == c_LAST_BYTE);
    assign o_word      = r_buf;

endmodule : imem_word_packer
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Boot-time loader for the instruction memory. It receives a
//             stream of the form LEN[7:0], LEN[15:8], LEN x 4 bytes from the
//             UART. It writes each little-endian word to address k and then
//             releases the core. While the core runs, it flags fetches past
//             the end of the loaded program.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             boot_req              - restart loading (pulse)
//             rx_data/valid/ready   - byte stream handshake
//             im_we/waddr/wdata     - instruction-memory write port
//             cpu_hold              - core held while loading
//             fetch_addr, fetch_oob - core byte PC, out-of-program flag
//             load_done             - program loaded, core running
//             err                   - header length exceeded memory depth
//  Revision : 1.0  initial release
// ============================================================================
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_oob,
    output logic              load_done,
    output logic              err
);

    localparam int               c_DEPTH   = 2 ** ADDR_W;
    localparam logic [LEN_W:0]   c_DEPTH_W = (LEN_W + 1)'(c_DEPTH);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic             r_err;

    logic             w_hs;
    logic             w_byte_stb;
    logic             w_word_done;
    logic [31:0]      w_word;
    logic             w_in_write;
    logic [LEN_W-1:0] w_len_full;
    logic [LEN_W-1:0] w_idx_inc;
    logic             w_unused_fetch_lsbs;

    // boot_req masks ready so that a byte offered in the same cycle stays
    // with the sender and becomes the first byte of the new header.
    assign rx_ready = ((r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA)   || (r_state == ST_ERROR)) && !boot_req;
    assign w_hs       = rx_valid && rx_ready;
    assign w_byte_stb = w_hs && (r_state == ST_DATA);
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_idx_inc  = r_idx + LEN_W'(1);

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (boot_req),
        .i_byte_stb  (w_byte_stb),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset || boot_req) begin
            r_state <= ST_LEN_LO;
            r_len   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_LEN_LO: begin
                    if (w_hs) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_hs) begin
                        r_len <= w_len_full;
                        if (w_len_full == '0) begin
                            r_state <= ST_RUN;
                        end else if ({1'b0, w_len_full} > c_DEPTH_W) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_done) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_idx   <= w_idx_inc;
                    r_state <= (w_idx_inc == r_len) ? ST_RUN : ST_DATA;
                end
                ST_RUN:   r_state <= ST_RUN;
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_LEN_LO;
            endcase
        end
    end

    // The write port is decoded only from registers. The packer buffer stays
    // stable through WRITE because no byte is accepted in that state.
    assign w_in_write = (r_state == ST_WRITE);
    assign im_we      = w_in_write;
    assign im_waddr   = w_in_write ? r_idx[ADDR_W-1:0] : '0;
    assign im_wdata   = w_in_write ? w_word : '0;

    assign cpu_hold  = (r_state != ST_RUN);
    assign load_done = (r_state == ST_RUN);
    assign err       = r_err;

    // Compare the word index of the PC with the loaded word count. The
    // byte-offset bits do not take part.
    assign fetch_oob = (r_state == ST_RUN) &&
                       (fetch_addr[31:2] >= {{(30 - LEN_W){1'b0}}, r_len});
    assign w_unused_fetch_lsbs = ^fetch_addr[1:0];

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader. It drives directed
//             byte streams, records every write on the memory port, and
//             compares the results with hand-computed values. The fetch
//             range checks come from a table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              boot_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic [31:0]       fetch_addr;
    logic              fetch_oob;
    logic              load_done;
    logic              err;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .boot_req   (boot_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .fetch_addr (fetch_addr),
        .fetch_oob  (fetch_oob),
        .load_done  (load_done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: one queue entry for every cycle that im_we is high.
    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    always @(negedge clk) begin
        if (im_we) begin
            wq_addr.push_back(im_waddr);
            wq_data.push_back(im_wdata);
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        exp_oob;
    } oob_vec_t;
    oob_vec_t oob_tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one byte and hold it until the handshake completes. Returns
    // #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
        accept_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic boot_pulse();
        @(posedge clk);
        #1;
        boot_req = 1'b1;
        @(negedge clk);
        check("ready_masked_by_boot", rx_ready, 0);
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        @(negedge clk);
        while (!load_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, load_done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  s1 [10];
        logic [7:0]  s3 [14];
        logic [31:0] w;
        int          first_cyc;
        int          n;
        int          bad;

        s1 = '{8'h02, 8'h00, 8'h13, 8'h03, 8'h00, 8'h08, 8'h83, 8'h23, 8'h03, 8'h00};
        s3 = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
               8'h13, 8'h01, 8'h20, 8'h00};

        oob_tab[0] = '{32'h0000_0000, 1'b0};
        oob_tab[1] = '{32'h0000_0008, 1'b0};
        oob_tab[2] = '{32'h0000_000B, 1'b0};
        oob_tab[3] = '{32'h0000_000C, 1'b1};
        oob_tab[4] = '{32'h0000_0010, 1'b1};
        oob_tab[5] = '{32'h0000_0400, 1'b1};
        oob_tab[6] = '{32'hFFFF_FFFF, 1'b1};
        oob_tab[7] = '{32'h0000_0006, 1'b0};

        reset      = 1'b1;
        boot_req   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        fetch_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_rx_ready",  rx_ready,  1);
        check("rst_cpu_hold",  cpu_hold,  1);
        check("rst_im_we",     im_we,     0);
        check("rst_im_waddr",  im_waddr,  0);
        check("rst_im_wdata",  im_wdata,  0);
        check("rst_load_done", load_done, 0);
        check("rst_err",       err,       0);
        check("rst_fetch_oob", fetch_oob, 0);
        @(posedge clk);
        #1;
        wq_addr.delete();
        wq_data.delete();

        // Two-word program with a continuously valid stream
        first_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            send_byte(s1[i]);
            if (i == 0) first_cyc = accept_cyc;
        end
        n = 0;
        @(negedge clk);
        while (cpu_hold && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_hold_latency", cyc - first_cyc, 12);
        check("t1_load_done",    load_done, 1);
        check("t1_write_count",  wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check("t1_addr0", wq_addr[0], 0);
            check("t1_data0", wq_data[0], 32'h0800_0313);
            check("t1_addr1", wq_addr[1], 1);
            check("t1_data1", wq_data[1], 32'h0003_2383);
        end
        check("t1_run_ready", rx_ready, 0);
        fetch_addr = 32'h4;
        #1 check("t1_oob_in", fetch_oob, 0);
        fetch_addr = 32'h8;
        #1 check("t1_oob_out", fetch_oob, 1);
        fetch_addr = 32'h0;

        // One-word program with rx_valid toggled every other cycle
        boot_pulse();
        check("t2_restart_hold", cpu_hold, 1);
        foreach (s1[i]) begin end
        begin
            logic [7:0] s2 [6];
            s2 = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h80, 8'h3E};
            for (int i = 0; i < 6; i++) begin
                send_byte(s2[i]);
                @(posedge clk);
                #1;
            end
        end
        wait_run("t2_run");
        check("t2_write_count", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            check("t2_addr0", wq_addr[0], 0);
            check("t2_data0", wq_data[0], 32'h3E80_0093);
        end

        // Zero-length header goes straight to RUN
        boot_pulse();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("t3_load_done",   load_done, 1);
        check("t3_write_count", wq_addr.size(), 0);
        fetch_addr = 32'h0;
        #1 check("t3_oob_zero", fetch_oob, 1);

        // Oversized header, drain, then recovery with a 3-word load
        boot_pulse();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        check("t4_err",       err,      1);
        check("t4_hold",      cpu_hold, 1);
        check("t4_drain_rdy", rx_ready, 1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        @(negedge clk);
        check("t4_err_sticky",  err,       1);
        check("t4_not_running", load_done, 0);
        check("t4_no_writes",   wq_addr.size(), 0);
        boot_pulse();
        @(negedge clk);
        check("t4_err_cleared", err, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) send_byte(s3[i]);
        wait_run("t4_run");
        check("t4_write_count", wq_addr.size(), 3);
        if (wq_addr.size() == 3) begin
            check("t4_data0", wq_data[0], 32'h0000_0013);
            check("t4_data1", wq_data[1], 32'h0010_0093);
            check("t4_addr2", wq_addr[2], 2);
            check("t4_data2", wq_data[2], 32'h0020_0113);
        end
        for (int i = 0; i < 8; i++) begin
            fetch_addr = oob_tab[i].addr;
            #1 check($sformatf("oob_tab[%0d]", i), fetch_oob, oob_tab[i].exp_oob);
        end
        fetch_addr = 32'h0;

        // boot_req coincident with a handshake halfway through a word
        boot_pulse();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        boot_req = 1'b1;
        @(negedge clk);
        check("t5_ready_low", rx_ready, 0);
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        rx_valid = 1'b0;
        check("t5_no_partial_write", wq_addr.size(), 0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        wait_run("t5_run");
        check("t5_write_count", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            check("t5_addr0", wq_addr[0], 0);
            check("t5_data0", wq_data[0], 32'h1122_3344);
        end

        // Full-depth program: 256 words, last write at address 255
        boot_pulse();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int k = 0; k < 256; k++) begin
            w = 32'h1000_0000 | 32'(k);
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        end
        wait_run("t6_run");
        check("t6_write_count", wq_addr.size(), 256);
        bad = 0;
        for (int k = 0; k < wq_addr.size(); k++) begin
            if (wq_addr[k] !== 8'(k) || wq_data[k] !== (32'h1000_0000 | 32'(k))) bad++;
        end
        check("t6_contents_bad", bad, 0);
        if (wq_addr.size() == 256) begin
            check("t6_last_addr", wq_addr[255], 255);
            check("t6_last_data", wq_data[255], 32'h1000_00FF);
        end
        check("t6_err", err, 0);
        fetch_addr = 32'h0000_03FC;
        #1 check("t6_oob_last", fetch_oob, 0);
        fetch_addr = 32'h0000_0400;
        #1 check("t6_oob_past", fetch_oob, 1);

        // Mid-load reset returns to the reset state
        boot_pulse();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h55);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t7_hold",  cpu_hold, 1);
        check("t7_ready", rx_ready, 1);
        check("t7_oob",   fetch_oob, 0);
        check("t7_no_writes", wq_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_boot_loader
`default_nettype wire
